// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master among NUM_REQ requesters.
// It latches the owner's config for each job, has a BUSY watchdog, and enforces a CS-high gap between jobs.
module spi_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CS_WIDTH   = 2,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*CS_WIDTH-1:0] req_cs_addr,
    input  logic [NUM_REQ*16-1:0]       req_len,
    input  logic [NUM_REQ*8-1:0]        req_tx_data,
    input  logic [NUM_REQ-1:0]          cfg_cpol,
    input  logic [NUM_REQ-1:0]          cfg_cpha,
    input  logic [NUM_REQ*8-1:0]        cfg_div,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done_out,
    output logic [NUM_REQ-1:0]          err_out,
    output logic                        busy,
    output logic                        m_enable,
    output logic                        m_start,
    output logic [CS_WIDTH-1:0]         m_cs_addr,
    output logic [15:0]                 m_tx_length,
    output logic [7:0]                  m_tx_data,
    output logic                        m_cpol,
    output logic                        m_cpha,
    output logic [7:0]                  m_sck_div,
    input  logic                        m_done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [15:0]        WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t              state_reg;
    logic [IDX_W-1:0]    ptr_reg;
    logic [IDX_W-1:0]    owner_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic [NUM_REQ-1:0]  done_reg;
    logic [NUM_REQ-1:0]  err_reg;
    logic                busy_reg;
    logic                enable_reg;
    logic                start_reg;
    logic [CS_WIDTH-1:0] cs_reg;
    logic [15:0]         len_reg;
    logic                cpol_reg;
    logic                cpha_reg;
    logic [7:0]          div_reg;
    logic [15:0]         wd_reg;
    logic [GAP_W-1:0]    gap_reg;

    logic [CS_WIDTH-1:0] cs_arr  [NUM_REQ];
    logic [15:0]         len_arr [NUM_REQ];
    logic [7:0]          tx_arr  [NUM_REQ];
    logic [7:0]          div_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign cs_arr[gi]  = req_cs_addr[gi*CS_WIDTH +: CS_WIDTH];
            assign len_arr[gi] = req_len[gi*16 +: 16];
            assign tx_arr[gi]  = req_tx_data[gi*8 +: 8];
            assign div_arr[gi] = cfg_div[gi*8 +: 8];
        end
    endgenerate

    // First requester at or after the pointer, wrapping around.
    logic [IDX_W-1:0] pick_next;
    logic             pick_valid;

    always_comb begin
        logic [SUM_W-1:0] cand_sum;
        logic [IDX_W-1:0] cand_idx;
        pick_next  = '0;
        pick_valid = 1'b0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr_reg} + SUM_W'(i);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_next  = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            grant_reg  <= '0;
            done_reg   <= '0;
            err_reg    <= '0;
            busy_reg   <= 1'b0;
            enable_reg <= 1'b1;
            start_reg  <= 1'b0;
            cs_reg     <= '0;
            len_reg    <= '0;
            cpol_reg   <= 1'b0;
            cpha_reg   <= 1'b0;
            div_reg    <= '0;
            wd_reg     <= '0;
            gap_reg    <= '0;
        end else begin
            start_reg  <= 1'b0;
            done_reg   <= '0;
            err_reg    <= '0;
            enable_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        owner_reg <= pick_next;
                        grant_reg <= GRANT_ONE << pick_next;
                        cs_reg    <= cs_arr[pick_next];
                        len_reg   <= len_arr[pick_next];
                        cpol_reg  <= cfg_cpol[pick_next];
                        cpha_reg  <= cfg_cpha[pick_next];
                        div_reg   <= div_arr[pick_next];
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    start_reg <= 1'b1;
                    wd_reg    <= '0;
                    state_reg <= BUSY;
                end
                BUSY: begin
                    // m_done is tested first so a completion on the timeout cycle is not an error.
                    if (m_done) begin
                        done_reg  <= grant_reg;
                        grant_reg <= '0;
                        gap_reg   <= '0;
                        state_reg <= GAP;
                    end else if (wd_reg == WD_LAST) begin
                        err_reg    <= grant_reg;
                        enable_reg <= 1'b0;
                        grant_reg  <= '0;
                        gap_reg    <= '0;
                        state_reg  <= GAP;
                    end else begin
                        wd_reg <= wd_reg + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        ptr_reg   <= (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant       = grant_reg;
    assign done_out    = done_reg;
    assign err_out     = err_reg;
    assign busy        = busy_reg;
    assign m_enable    = enable_reg;
    assign m_start     = start_reg;
    assign m_cs_addr   = cs_reg;
    assign m_tx_length = len_reg;
    assign m_cpol      = cpol_reg;
    assign m_cpha      = cpha_reg;
    assign m_sck_div   = div_reg;
    assign m_tx_data   = (grant_reg != '0) ? tx_arr[owner_reg] : 8'd0;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: round-robin order, latched config, latencies,
// watchdog abort, CS gap, idle m_done and asynchronous reset.
module tb_spi_master_arbiter;
    localparam int N   = 4;
    localparam int CSW = 2;
    localparam int GAP = 4;
    localparam int TMO = 20;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*CSW-1:0] req_cs_addr;
    logic [N*16-1:0]  req_len;
    logic [N*8-1:0]   req_tx_data;
    logic [N-1:0]   cfg_cpol;
    logic [N-1:0]   cfg_cpha;
    logic [N*8-1:0] cfg_div;
    logic [N-1:0]   grant;
    logic [N-1:0]   done_out;
    logic [N-1:0]   err_out;
    logic           busy;
    logic           m_enable;
    logic           m_start;
    logic [CSW-1:0] m_cs_addr;
    logic [15:0]    m_tx_length;
    logic [7:0]     m_tx_data;
    logic           m_cpol;
    logic           m_cpha;
    logic [7:0]     m_sck_div;
    logic           m_done;

    spi_master_arbiter #(
        .NUM_REQ(N), .CS_WIDTH(CSW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_cs_addr(req_cs_addr),
        .req_len(req_len), .req_tx_data(req_tx_data), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .grant(grant), .done_out(done_out),
        .err_out(err_out), .busy(busy), .m_enable(m_enable), .m_start(m_start),
        .m_cs_addr(m_cs_addr), .m_tx_length(m_tx_length), .m_tx_data(m_tx_data),
        .m_cpol(m_cpol), .m_cpha(m_cpha), .m_sck_div(m_sck_div), .m_done(m_done)
    );

    typedef struct {
        int owner;
        int cs;
        int len;
        int tx;
        int cpol;
        int cpha;
        int div;
        int k;          // m_done arrives in BUSY cycle k; 0 means never (watchdog)
        int exp_start;  // expected m_start cycle, or -1 to check the CS gap instead
    } job_t;

    job_t start_q[$];
    job_t done_q[$];
    int   delay_q[$];

    int cs_v[N], len_v[N], tx_v[N], cpol_v[N], cpha_v[N], div_v[N], dly_v[N];
    bit drop_v[N], scr_v[N];
    int rr_ptr;
    int cyc = 0;
    int completed;
    int n_checks;
    int n_pass;
    int start_cyc;
    int last_done_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) begin
            req_cs_addr[i*CSW +: CSW] = CSW'(cs_v[i]);
            req_len[i*16 +: 16]       = 16'(len_v[i]);
            req_tx_data[i*8 +: 8]     = 8'(tx_v[i]);
            cfg_cpol[i]               = cpol_v[i][0];
            cfg_cpha[i]               = cpha_v[i][0];
            cfg_div[i*8 +: 8]         = 8'(div_v[i]);
        end
    endtask

    task automatic randomize_cfg();
        for (int i = 0; i < N; i++) begin
            cs_v[i]   = int'($urandom_range(0, 3));
            len_v[i]  = int'($urandom_range(0, 65535));
            tx_v[i]   = int'($urandom_range(0, 255));
            cpol_v[i] = int'($urandom_range(0, 1));
            cpha_v[i] = int'($urandom_range(0, 1));
            div_v[i]  = int'($urandom_range(0, 255));
        end
        apply_cfg();
    endtask

    task automatic set_plain(input int d);
        for (int i = 0; i < N; i++) begin
            dly_v[i]  = d;
            drop_v[i] = 1'b0;
            scr_v[i]  = 1'b0;
        end
    endtask

    task automatic push_job(input int idx, input int exp_start);
        job_t j;
        j.owner = idx;
        j.cs = cs_v[idx];
        j.len = len_v[idx];
        j.tx = tx_v[idx];
        j.cpol = cpol_v[idx];
        j.cpha = cpha_v[idx];
        j.div = div_v[idx];
        j.k = dly_v[idx];
        j.exp_start = exp_start;
        start_q.push_back(j);
        done_q.push_back(j);
        delay_q.push_back(dly_v[idx]);
    endtask

    // Requests in r are all held until their own completion, so service order is
    // simply the set walked cyclically from the pointer.
    task automatic run_round(input logic [N-1:0] r);
        int  target;
        int  budget;
        int  last;
        int  idx;
        bit  first;
        @(negedge clk);
        first = 1'b1;
        last  = rr_ptr;
        for (int i = 0; i < N; i++) begin
            idx = (rr_ptr + i) % N;
            if (r[idx]) begin
                push_job(idx, first ? cyc + 2 : -1);
                first = 1'b0;
                last  = idx;
            end
        end
        rr_ptr = (last + 1) % N;
        target = completed + $countones(r);
        budget = $countones(r) * (TMO + GAP + 8) + 20;
        req = req | r;
        while (completed < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("round_complete", completed, target);
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_grant"}, int'(grant), 0);
        check({tag, "_done"}, int'(done_out), 0);
        check({tag, "_err"}, int'(err_out), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_start"}, int'(m_start), 0);
        check({tag, "_enable"}, int'(m_enable), 1);
        check({tag, "_cs"}, int'(m_cs_addr), 0);
        check({tag, "_len"}, int'(m_tx_length), 0);
        check({tag, "_div"}, int'(m_sck_div), 0);
        check({tag, "_cpol"}, int'(m_cpol), 0);
        check({tag, "_cpha"}, int'(m_cpha), 0);
        check({tag, "_txdata"}, int'(m_tx_data), 0);
    endtask

    // Stand-in spi_master: raises m_done in the chosen BUSY cycle.
    initial begin : slave
        int k;
        m_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && m_start) begin
                k = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                if (k > 0) begin
                    repeat (k - 1) @(negedge clk);
                    m_done = 1'b1;
                    @(posedge clk);
                    #1 m_done = 1'b0;
                end
            end
        end
    end

    // Requesters: drop req on completion (or early, at start), optionally scramble config mid-job.
    initial begin : requesters
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (done_out[i] || err_out[i]) req[i] = 1'b0;
                    if (m_start && grant[i]) begin
                        if (drop_v[i]) req[i] = 1'b0;
                        if (scr_v[i]) begin
                            cs_v[i]   = int'($urandom_range(0, 3));
                            len_v[i]  = int'($urandom_range(0, 65535));
                            cpol_v[i] = int'($urandom_range(0, 1));
                            cpha_v[i] = int'($urandom_range(0, 1));
                            div_v[i]  = int'($urandom_range(0, 255));
                        end
                    end
                end
                apply_cfg();
            end
        end
    end

    initial begin : monitor
        job_t j;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_start) begin
                    if (start_q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        j = start_q.pop_front();
                        $display("start  cyc=%0d owner=%0d grant=%b cs=%0d len=%0d div=%0d",
                                 cyc, j.owner, grant, m_cs_addr, m_tx_length, m_sck_div);
                        check("start_grant", int'(grant), 1 << j.owner);
                        check("start_cs", int'(m_cs_addr), j.cs);
                        check("start_len", int'(m_tx_length), j.len);
                        check("start_txdata", int'(m_tx_data), j.tx);
                        check("start_cpol", int'(m_cpol), j.cpol);
                        check("start_cpha", int'(m_cpha), j.cpha);
                        check("start_div", int'(m_sck_div), j.div);
                        check("start_busy", int'(busy), 1);
                        if (j.exp_start >= 0) check("req_to_start", cyc, j.exp_start);
                        else check("cs_gap", cyc - last_done_cyc, GAP + 2);
                        start_cyc = cyc;
                    end
                end
                if (done_out != '0 || err_out != '0) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        j = done_q.pop_front();
                        $display("finish cyc=%0d owner=%0d done=%b err=%b enable=%0d",
                                 cyc, j.owner, done_out, err_out, m_enable);
                        check("done_vec", int'(done_out), (j.k > 0) ? (1 << j.owner) : 0);
                        check("err_vec", int'(err_out), (j.k > 0) ? 0 : (1 << j.owner));
                        check("enable", int'(m_enable), (j.k > 0) ? 1 : 0);
                        check("latency", cyc - start_cyc, (j.k > 0) ? j.k : TMO);
                        check("gap_grant", int'(grant), 0);
                        check("gap_txdata", int'(m_tx_data), 0);
                        check("gap_busy", int'(busy), 1);
                        check("hold_cs", int'(m_cs_addr), j.cs);
                        check("hold_len", int'(m_tx_length), j.len);
                        check("hold_div", int'(m_sck_div), j.div);
                        check("hold_cpol", int'(m_cpol), j.cpol);
                        last_done_cyc = cyc;
                        completed++;
                    end
                end
            end
        end
    end

    initial begin : guard
        #800000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        int budget;
        rst_n = 1'b0;
        req = '0;
        n_checks = 0;
        n_pass = 0;
        completed = 0;
        rr_ptr = 0;
        start_cyc = 0;
        last_done_cyc = 0;
        set_plain(3);
        randomize_cfg();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // All four from reset: served 0,1,2,3.
        run_round(4'b1111);

        // Single requester 2, addr 1, len 3.
        cs_v[2] = 1;
        len_v[2] = 3;
        apply_cfg();
        set_plain(5);
        run_round(4'b0100);

        // Mode switches between consecutive jobs.
        cpol_v[1] = 1; cpha_v[1] = 0; div_v[1] = 8;
        cpol_v[2] = 0; cpha_v[2] = 1; div_v[2] = 2;
        apply_cfg();
        set_plain(2);
        run_round(4'b0110);

        // Watchdog abort on requester 3, then requester 0 served after the gap.
        set_plain(4);
        dly_v[3] = 0;
        run_round(4'b1001);

        // m_done on the watchdog's last cycle: completion, not error.
        set_plain(TMO);
        run_round(4'b0010);

        for (int r = 0; r < 24; r++) begin
            randomize_cfg();
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 9))
                    0: dly_v[i] = 0;
                    1: dly_v[i] = TMO;
                    default: dly_v[i] = int'($urandom_range(1, TMO - 1));
                endcase
                drop_v[i] = 1'($urandom_range(0, 1));
                scr_v[i]  = 1'($urandom_range(0, 1));
            end
            run_round(N'($urandom_range(1, 15)));
        end

        // m_done while idle must produce nothing.
        @(negedge clk);
        m_done = 1'b1;
        @(posedge clk);
        #1 m_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_busy", int'(busy), 0);
            check("idle_start", int'(m_start), 0);
            check("idle_done", int'(done_out), 0);
            check("idle_err", int'(err_out), 0);
        end

        // Leave the pointer at 2 so a reset-to-0 is observable.
        randomize_cfg();
        set_plain(3);
        run_round(4'b0010);

        // Job on requester 1 that never completes, cut short by reset.
        set_plain(0);
        @(negedge clk);
        push_job(1, cyc + 2);
        req[1] = 1'b1;
        budget = 10;
        while (start_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reset_job_started", start_q.size(), 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        start_q.delete();
        done_q.delete();
        delay_q.delete();
        req = '0;
        rr_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // After reset the pointer restarts at requester 0.
        randomize_cfg();
        for (int i = 0; i < N; i++) dly_v[i] = int'($urandom_range(1, TMO - 1));
        run_round(4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
